pipe_ctrl_unit: RTL and testbench

//  Pipeline control unit (CU): sole driver of the stage-register control flags (cu2_refresh_flag_i of IF/ID, ID/EX).

---
 rtl/pipe_ctrl_unit_pkg.sv | 23 ++
 rtl/pipe_ctrl_unit_if.sv | 40 ++++
 rtl/pipe_ctrl_unit_sat_counter.sv | 23 ++
 rtl/pipe_ctrl_unit.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared constants, state encoding and hazard helper for the pipeline control unit.
package pipe_ctrl_unit_pkg;

  localparam logic        ENABLE          = 1'b1;
  localparam logic        DISABLE         = 1'b0;
  localparam logic [6:0]  OPCODE_LOAD     = 7'b0000011;
  localparam logic [31:0] DEFAULT_32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } cu_state_e;

  // x0 is never a real dependency, so a load targeting it cannot cause a stall.
  function automatic logic is_load_use(input logic [6:0] opcode,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return (opcode == OPCODE_LOAD) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit signal bundle; master is the control unit, slave is the pipeline side.
interface pipe_ctrl_unit_if #(parameter int CNT_W = 32);

  logic [4:0]       id2cu_rs1_i;
  logic [4:0]       id2cu_rs2_i;
  logic [6:0]       idex2cu_opcode_i;
  logic [4:0]       idex2cu_rd_i;
  logic             ex2cu_jump_flag_i;
  logic [31:0]      ex2cu_jump_addr_i;
  logic             bus2cu_hold_req_i;
  logic             cu2pc_hold_o;
  logic             cu2pc_jump_flag_o;
  logic [31:0]      cu2pc_jump_addr_o;
  logic             cu2ifid_hold_o;
  logic             cu2ifid_refresh_flag_o;
  logic             cu2idex_hold_o;
  logic             cu2idex_refresh_flag_o;
  logic [1:0]       cu_state_o;
  logic [CNT_W-1:0] cu_stall_cnt_o;
  logic [CNT_W-1:0] cu_flush_cnt_o;

  modport master (
    input  id2cu_rs1_i, id2cu_rs2_i, idex2cu_opcode_i, idex2cu_rd_i,
           ex2cu_jump_flag_i, ex2cu_jump_addr_i, bus2cu_hold_req_i,
    output cu2pc_hold_o, cu2pc_jump_flag_o, cu2pc_jump_addr_o,
           cu2ifid_hold_o, cu2ifid_refresh_flag_o,
           cu2idex_hold_o, cu2idex_refresh_flag_o,
           cu_state_o, cu_stall_cnt_o, cu_flush_cnt_o
  );

  modport slave (
    output id2cu_rs1_i, id2cu_rs2_i, idex2cu_opcode_i, idex2cu_rd_i,
           ex2cu_jump_flag_i, ex2cu_jump_addr_i, bus2cu_hold_req_i,
    input  cu2pc_hold_o, cu2pc_jump_flag_o, cu2pc_jump_addr_o,
           cu2ifid_hold_o, cu2ifid_refresh_flag_o,
           cu2idex_hold_o, cu2idex_refresh_flag_o,
           cu_state_o, cu_stall_cnt_o, cu_flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: arbitrates bus hold, taken jumps and load-use stalls into
// PC / stage-register hold and bubble controls, with saturating stall/flush counters.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rest,
  pipe_ctrl_unit_if.master bus
);

  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] REM_START = REM_W'(FLUSH_CYCLES - 1);

  cu_state_e        r_state, r_saved_state;
  logic [REM_W-1:0] r_rem, r_saved_rem;

  cu_state_e        w_eff_state, w_next_state;
  logic [REM_W-1:0] w_eff_rem, w_next_rem;
  logic             w_hold_req, w_jump, w_hazard, w_jump_act, w_lu_act;
  logic             w_pc_hold, w_jump_flag, w_ifid_hold, w_ifid_refresh;
  logic             w_idex_hold, w_idex_refresh;
  logic [31:0]      w_jump_addr;
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  // The release cycle of HOLD already behaves as the saved state, so a jump
  // waiting in EX is taken immediately and a paused flush keeps its count.
  assign w_eff_state = (r_state == ST_HOLD) ? r_saved_state : r_state;
  assign w_eff_rem   = (r_state == ST_HOLD) ? r_saved_rem   : r_rem;

  assign w_hold_req = bus.bus2cu_hold_req_i;
  assign w_jump     = bus.ex2cu_jump_flag_i;
  assign w_hazard   = is_load_use(bus.idex2cu_opcode_i, bus.idex2cu_rd_i,
                                  bus.id2cu_rs1_i, bus.id2cu_rs2_i);
  assign w_jump_act = !w_hold_req && w_jump;
  assign w_lu_act   = !w_hold_req && !w_jump && (w_eff_state == ST_RUN) && w_hazard;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state       <= ST_RUN;
      r_rem         <= '0;
      r_saved_state <= ST_RUN;
      r_saved_rem   <= '0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
      if (w_hold_req) begin
        r_saved_state <= w_eff_state;
        r_saved_rem   <= w_eff_rem;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    if (w_hold_req) begin
      w_next_state = ST_HOLD;
    end else if (w_jump) begin
      if (FLUSH_CYCLES > 1) begin
        w_next_state = ST_FLUSH;
        w_next_rem   = REM_START;
      end else begin
        w_next_state = ST_RUN;
        w_next_rem   = '0;
      end
    end else if (w_eff_state == ST_FLUSH) begin
      if (w_eff_rem <= REM_W'(1)) begin
        w_next_state = ST_RUN;
        w_next_rem   = '0;
      end else begin
        w_next_state = ST_FLUSH;
        w_next_rem   = w_eff_rem - REM_W'(1);
      end
    end else begin
      w_next_state = ST_RUN;
      w_next_rem   = '0;
    end
  end

  always_comb begin
    w_pc_hold      = 1'b0;
    w_jump_flag    = 1'b0;
    w_jump_addr    = DEFAULT_32_ZERO;
    w_ifid_hold    = 1'b0;
    w_ifid_refresh = ENABLE;
    w_idex_hold    = 1'b0;
    w_idex_refresh = ENABLE;
    if (w_hold_req) begin
      w_pc_hold   = 1'b1;
      w_ifid_hold = 1'b1;
      w_idex_hold = 1'b1;
    end else if (w_jump) begin
      w_jump_flag    = 1'b1;
      w_jump_addr    = bus.ex2cu_jump_addr_i;
      w_ifid_refresh = DISABLE;
      w_idex_refresh = DISABLE;
    end else if (w_eff_state == ST_FLUSH) begin
      w_ifid_refresh = DISABLE;
      w_idex_refresh = DISABLE;
    end else if (w_lu_act) begin
      w_pc_hold      = 1'b1;
      w_ifid_hold    = 1'b1;
      w_idex_refresh = DISABLE;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rest (rest),
    .inc  (w_lu_act),
    .cnt  (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rest (rest),
    .inc  (w_jump_act),
    .cnt  (w_flush_cnt)
  );

  assign bus.cu2pc_hold_o           = w_pc_hold;
  assign bus.cu2pc_jump_flag_o      = w_jump_flag;
  assign bus.cu2pc_jump_addr_o      = w_jump_addr;
  assign bus.cu2ifid_hold_o         = w_ifid_hold;
  assign bus.cu2ifid_refresh_flag_o = w_ifid_refresh;
  assign bus.cu2idex_hold_o         = w_idex_hold;
  assign bus.cu2idex_refresh_flag_o = w_idex_refresh;
  assign bus.cu_state_o             = r_state;
  assign bus.cu_stall_cnt_o         = w_stall_cnt;
  assign bus.cu_flush_cnt_o         = w_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed scoreboard bench for pipe_ctrl_unit; a second instance with 2-bit
// counters receives identical stimulus to exercise counter saturation.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  // Flag order: {pcHold, jumpFlag, ifidHold, ifidRefresh, idexHold, idexRefresh}
  localparam logic [5:0] F_IDLE = 6'b000101;
  localparam logic [5:0] F_LU   = 6'b101100;
  localparam logic [5:0] F_JMP  = 6'b010000;
  localparam logic [5:0] F_FLS  = 6'b000000;
  localparam logic [5:0] F_HLD  = 6'b101111;

  typedef struct {
    logic [1:0]  st;
    logic [5:0]  flags;
    logic [31:0] addr;
    int          stall;
    int          flush;
  } exp_t;

  logic clk;
  logic rest;
  int   checks = 0;
  int   passed = 0;
  exp_t sbQ[$];

  pipe_ctrl_unit_if #(.CNT_W(32)) ifMain ();
  pipe_ctrl_unit_if #(.CNT_W(2))  ifSat ();

  pipe_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (ifMain)
  );

  pipe_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dutSat (
    .clk  (clk),
    .rest (rest),
    .bus  (ifSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int satCnt(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic applyStimulus(input logic hold, input logic jump, input logic [31:0] addr,
                               input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [1:0] st, input logic [5:0] flags,
                               input logic [31:0] addrExp, input int stall, input int flush);
    exp_t e;
    ifMain.bus2cu_hold_req_i = hold;  ifSat.bus2cu_hold_req_i = hold;
    ifMain.ex2cu_jump_flag_i = jump;  ifSat.ex2cu_jump_flag_i = jump;
    ifMain.ex2cu_jump_addr_i = addr;  ifSat.ex2cu_jump_addr_i = addr;
    ifMain.idex2cu_opcode_i  = op;    ifSat.idex2cu_opcode_i  = op;
    ifMain.idex2cu_rd_i      = rd;    ifSat.idex2cu_rd_i      = rd;
    ifMain.id2cu_rs1_i       = rs1;   ifSat.id2cu_rs1_i       = rs1;
    ifMain.id2cu_rs2_i       = rs2;   ifSat.id2cu_rs2_i       = rs2;
    e.st = st; e.flags = flags; e.addr = addrExp; e.stall = stall; e.flush = flush;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [5:0] obsFlags;
    if (sbQ.size() == 0) begin
      chk("scoreboardEmpty", 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      obsFlags = {ifMain.cu2pc_hold_o, ifMain.cu2pc_jump_flag_o, ifMain.cu2ifid_hold_o,
                  ifMain.cu2ifid_refresh_flag_o, ifMain.cu2idex_hold_o,
                  ifMain.cu2idex_refresh_flag_o};
      chk("state",    {30'd0, ifMain.cu_state_o}, {30'd0, e.st});
      chk("flags",    {26'd0, obsFlags},          {26'd0, e.flags});
      chk("jumpAddr", ifMain.cu2pc_jump_addr_o,   e.addr);
      chk("stallCnt", ifMain.cu_stall_cnt_o,      32'(e.stall));
      chk("flushCnt", ifMain.cu_flush_cnt_o,      32'(e.flush));
      chk("satStall", {30'd0, ifSat.cu_stall_cnt_o}, 32'(satCnt(e.stall)));
      chk("satFlush", {30'd0, ifSat.cu_flush_cnt_o}, 32'(satCnt(e.flush)));
    end
  endtask

  task automatic runStep(input logic hold, input logic jump, input logic [31:0] addr,
                         input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] st, input logic [5:0] flags,
                         input logic [31:0] addrExp, input int stall, input int flush);
    applyStimulus(hold, jump, addr, op, rd, rs1, rs2, st, flags, addrExp, stall, flush);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rest = 1'b0;
    applyStimulus(0, 0, 32'h0, OP_ALU, 5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0, 0, 0);
    #2;
    checkOutput();
    #1 rest = 1'b1;
    @(posedge clk);
    #1;

    // Load-use stalls, including the rs2 match, rd=x0 and non-load cases
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   0, 0);
    runStep(0, 0, 32'h0,   OP_LOAD, 5'd5, 5'd5, 5'd0, 2'd0, F_LU,   32'h0,   0, 0);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   1, 0);
    runStep(0, 0, 32'h0,   OP_LOAD, 5'd7, 5'd1, 5'd7, 2'd0, F_LU,   32'h0,   1, 0);
    runStep(0, 0, 32'h0,   OP_LOAD, 5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 0);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd5, 5'd5, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 0);

    // Taken jump, with load-use ignored while flushing
    runStep(0, 1, 32'h80,  OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_JMP,  32'h80,  2, 0);
    runStep(0, 0, 32'h0,   OP_LOAD, 5'd5, 5'd5, 5'd0, 2'd1, F_FLS,  32'h0,   2, 1);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 1);

    // Bus hold arriving mid-flush, then the remaining flush cycle
    runStep(0, 1, 32'h100, OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_JMP,  32'h100, 2, 1);
    runStep(1, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd1, F_HLD,  32'h0,   2, 2);
    runStep(1, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd2, F_HLD,  32'h0,   2, 2);
    runStep(1, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd2, F_HLD,  32'h0,   2, 2);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd2, F_FLS,  32'h0,   2, 2);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 2);

    // Hold + jump + load-use together; jump taken on release
    runStep(1, 1, 32'h200, OP_LOAD, 5'd3, 5'd3, 5'd0, 2'd0, F_HLD,  32'h0,   2, 2);
    runStep(1, 1, 32'h200, OP_LOAD, 5'd3, 5'd3, 5'd0, 2'd2, F_HLD,  32'h0,   2, 2);
    runStep(0, 1, 32'h200, OP_LOAD, 5'd3, 5'd3, 5'd0, 2'd2, F_JMP,  32'h200, 2, 2);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd1, F_FLS,  32'h0,   2, 3);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 3);

    // A second jump during FLUSH restarts the flush
    runStep(0, 1, 32'h40,  OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_JMP,  32'h40,  2, 3);
    runStep(0, 1, 32'h44,  OP_ALU,  5'd0, 5'd0, 5'd0, 2'd1, F_JMP,  32'h44,  2, 4);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd1, F_FLS,  32'h0,   2, 5);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   2, 5);

    // Asynchronous reset landing in the middle of a flush
    runStep(0, 1, 32'h80,  OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_JMP,  32'h80,  2, 5);
    applyStimulus(0, 0, 32'h0, OP_ALU, 5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0, 0, 0);
    #2 rest = 1'b0;
    #1;
    checkOutput();
    #1 rest = 1'b1;
    @(posedge clk);
    #1;
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   0, 0);

    // Five back-to-back jumps: the 2-bit instance must stick at 3
    for (int i = 0; i < 5; i++) begin
      runStep(0, 1, 32'(32'h300 + 4 * i), OP_ALU, 5'd0, 5'd0, 5'd0,
              (i == 0) ? 2'd0 : 2'd1, F_JMP, 32'(32'h300 + 4 * i), 0, i);
    end
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd1, F_FLS,  32'h0,   0, 5);
    runStep(0, 0, 32'h0,   OP_ALU,  5'd0, 5'd0, 5'd0, 2'd0, F_IDLE, 32'h0,   0, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
